// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice: default memory map
// and the arbiter FSM / address-region encodings.
package mem_arbiter_pkg;

  // Default memory map (byte addresses).
  localparam int unsigned MAP_INSTR_SIZE   = 512;    // instruction RAM [0, 512)
  localparam int unsigned MAP_DATA_SIZE    = 256;    // data RAM [512, 768)
  localparam int unsigned MAP_PERIPH_START = 'h800;  // peripherals [0x800, top)

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    REGION_INSTR  = 2'd0,
    REGION_DATA   = 2'd1,
    REGION_PERIPH = 2'd2,
    REGION_HOLE   = 2'd3
  } region_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter.
//   m0_* : core (requester 0), m1_* : loader/debug port (requester 1)
//   req/we/addr/wdata : request fields, held stable until gnt is seen
//   gnt               : high during the memory access cycle
//   rvalid/err        : one-cycle response pulse, err marks a rejected access
//   m_rdata           : read data shared by both requesters, valid with rvalid
// modport master = requester side, modport slave = arbiter side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic              m0_err;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic              m1_err;

  logic [DATA_W-1:0] m_rdata;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m0_gnt, m0_rvalid, m0_err,
    input  m1_gnt, m1_rvalid, m1_err,
    input  m_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m0_gnt, m0_rvalid, m0_err,
    output m1_gnt, m1_rvalid, m1_err,
    output m_rdata
  );
endinterface

// File: rtl/mem_access_check.sv
// Combinational address/permission decoder for one access.
//   addr   : byte address
//   we     : 1 = write
//   id     : requester (0 = core, 1 = loader/debug)
//   reject : misaligned, map hole, or core write into instruction RAM
//   region : decoded memory region
module mem_access_check
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W            = 12,
  parameter int unsigned INSTR_MEM_SIZE    = MAP_INSTR_SIZE,
  parameter int unsigned DATA_MEM_SIZE     = MAP_DATA_SIZE,
  parameter int unsigned PERIPH_ADDR_START = MAP_PERIPH_START
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              id,
  output logic              reject,
  output region_t           region
);

  logic [31:0] addr_u;
  logic        misaligned;
  logic        write_prot;

  always_comb begin
    addr_u = 32'(addr);
    if (addr_u < INSTR_MEM_SIZE) begin
      region = REGION_INSTR;
    end else if (addr_u < INSTR_MEM_SIZE + DATA_MEM_SIZE) begin
      region = REGION_DATA;
    end else if (addr_u >= PERIPH_ADDR_START) begin
      region = REGION_PERIPH;
    end else begin
      region = REGION_HOLE;
    end

    misaligned = (addr[1:0] != 2'b00);
    // Only the core is barred from instruction RAM; the loader must fill it.
    write_prot = !id && we && (region == REGION_INSTR);
    reject     = misaligned || (region == REGION_HOLE) || write_prot;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the unified memory.
//   clk, reset : clock, synchronous active-high reset
//   bus        : requester bus (slave side), see mem_arbiter_if
//   mem_A/WD/WE: registered address / write data, qualified write enable
//   mem_RD     : combinational read data from memory
// A request sampled at edge E is granted during cycle E+1 (memory driven
// from the access registers) and answered with rvalid/rdata in cycle E+2.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W            = 12,
  parameter int unsigned DATA_W            = 32,
  parameter int unsigned INSTR_MEM_SIZE    = MAP_INSTR_SIZE,
  parameter int unsigned DATA_MEM_SIZE     = MAP_DATA_SIZE,
  parameter int unsigned PERIPH_ADDR_START = MAP_PERIPH_START
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD
);

  arb_state_t        state, state_nxt;
  logic              rr;

  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_id;
  logic              acc_reject;
  region_t           acc_region;

  logic              gnt0, gnt1;
  logic              elig0, elig1, any_elig, win_id;
  logic              rd_ok;

  logic              rvalid0, rvalid1, err0, err1;
  logic [DATA_W-1:0] rdata_q;

  mem_access_check #(
    .ADDR_W            (ADDR_W),
    .INSTR_MEM_SIZE    (INSTR_MEM_SIZE),
    .DATA_MEM_SIZE     (DATA_MEM_SIZE),
    .PERIPH_ADDR_START (PERIPH_ADDR_START)
  ) u_check (
    .addr   (acc_addr),
    .we     (acc_we),
    .id     (acc_id),
    .reject (acc_reject),
    .region (acc_region)
  );

  // A requester being granted this cycle is masked so its not-yet-dropped
  // req is not taken as a new request.
  always_comb begin
    elig0    = bus.m0_req && !gnt0;
    elig1    = bus.m1_req && !gnt1;
    any_elig = elig0 || elig1;
    if (elig0 && elig1) begin
      win_id = rr;
    end else begin
      win_id = elig1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_elig) state_nxt = ACCESS;
      ACCESS:  state_nxt = any_elig ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  // mem_WE is also gated by reset so a write whose closing edge sees reset
  // never lands in memory.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    mem_WE = 1'b0;
    if (state == ACCESS) begin
      gnt0   = !acc_id;
      gnt1   = acc_id;
      mem_WE = acc_we && !acc_reject && !reset;
    end
  end

  assign rd_ok = !acc_we && !acc_reject && (acc_region != REGION_HOLE);

  // Access registers, round-robin pointer and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr        <= 1'b0;
      acc_addr  <= '0;
      acc_we    <= 1'b0;
      acc_wdata <= '0;
      acc_id    <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (any_elig) begin
        acc_addr  <= win_id ? bus.m1_addr  : bus.m0_addr;
        acc_we    <= win_id ? bus.m1_we    : bus.m0_we;
        acc_wdata <= win_id ? bus.m1_wdata : bus.m0_wdata;
        acc_id    <= win_id;
        rr        <= !win_id;
      end
      rvalid0 <= (state == ACCESS) && !acc_id;
      rvalid1 <= (state == ACCESS) &&  acc_id;
      err0    <= (state == ACCESS) && !acc_id && acc_reject;
      err1    <= (state == ACCESS) &&  acc_id && acc_reject;
      if (state == ACCESS) begin
        rdata_q <= rd_ok ? mem_RD : '0;
      end
    end
  end

  assign mem_A         = acc_addr;
  assign mem_WD        = acc_wdata;
  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rvalid0;
  assign bus.m1_rvalid = rvalid1;
  assign bus.m0_err    = err0;
  assign bus.m1_err    = err1;
  assign bus.m_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic from both requesters, checked against a transaction-level model
// (memory shadow image plus the access rules written as plain arithmetic).
module tb_mem_arbiter;

  localparam int unsigned AW     = 12;
  localparam int unsigned DW     = 32;
  localparam int unsigned NWORDS = 1024;
  localparam logic [31:0] SW_VAL = 32'h0000_5A3C;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          mem_init = 1'b1;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_WD;
  logic          mem_WE;
  logic [DW-1:0] mem_RD;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W            (AW),
    .DATA_W            (DW),
    .INSTR_MEM_SIZE    (512),
    .DATA_MEM_SIZE     (256),
    .PERIPH_ADDR_START ('h800)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .mem_A  (mem_A),
    .mem_WD (mem_WD),
    .mem_WE (mem_WE),
    .mem_RD (mem_RD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 128) return 32'hDEADBEEF;   // 0x200
    if (i == 512) return SW_VAL;         // 0x800 switch peripheral
    return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // Memory environment: word array covering the whole 12-bit space.
  logic [DW-1:0] mem_arr [NWORDS];
  assign mem_RD = mem_arr[mem_A[AW-1:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NWORDS; i++) mem_arr[i] <= init_word(i);
    end else if (mem_WE) begin
      mem_arr[mem_A[AW-1:2]] <= mem_WD;
    end
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] shadow [NWORDS];
  bit          pend [2];
  bit          wr [2];
  int unsigned ad [2];
  logic [31:0] wd [2];
  int          wait_cnt [2];
  bit          outst [2];
  bit          o_wr [2];
  bit          o_err [2];
  int unsigned o_addr [2];
  logic [31:0] o_wd [2];
  logic [31:0] o_data [2];
  bit          prev_g [2];
  bit          rst_q;
  int          cyc = 0;

  function automatic logic [9:0] widx(input int unsigned a);
    return 10'(a >> 2);
  endfunction

  function automatic bit exp_reject(input int id, input bit we, input int unsigned a);
    if (a % 4 != 0) return 1'b1;
    if (a >= 768 && a < 'h800) return 1'b1;
    if (id == 0 && we && a < 512) return 1'b1;
    return 1'b0;
  endfunction

  task automatic issue(input int id, input bit we, input int unsigned a, input logic [31:0] d);
    pend[id]     = 1'b1;
    wr[id]       = we;
    ad[id]       = a;
    wd[id]       = d;
    wait_cnt[id] = 0;
  endtask

  task automatic drive();
    bus.m0_req   = pend[0];
    bus.m0_we    = wr[0];
    bus.m0_addr  = AW'(ad[0]);
    bus.m0_wdata = wd[0];
    bus.m1_req   = pend[1];
    bus.m1_we    = wr[1];
    bus.m1_addr  = AW'(ad[1]);
    bus.m1_wdata = wd[1];
  endtask

  task automatic observe();
    logic [1:0] g, rv, er;
    bit rej;
    g  = {bus.m1_gnt, bus.m0_gnt};
    rv = {bus.m1_rvalid, bus.m0_rvalid};
    er = {bus.m1_err, bus.m0_err};
    if (rst_q) begin
      check_eq("rst_gnt", 32'(g), 32'd0);
      check_eq("rst_rvalid", 32'(rv), 32'd0);
      check_eq("rst_err", 32'(er), 32'd0);
      check_eq("rst_rdata", bus.m_rdata, 32'd0);
      check_eq("rst_mem_A", 32'(mem_A), 32'd0);
      check_eq("rst_mem_WD", mem_WD, 32'd0);
      check_eq("rst_mem_WE", 32'(mem_WE), 32'd0);
      for (int i = 0; i < 2; i++) begin
        outst[i]  = 1'b0;
        pend[i]   = 1'b0;
        prev_g[i] = 1'b0;
      end
      return;
    end
    // Responses first: a completed write must be visible to a read granted now.
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("m%0d_rvalid", i), 32'(rv[i]), 32'(outst[i]));
      if (outst[i]) begin
        check_eq($sformatf("m%0d_err", i), 32'(er[i]), 32'(o_err[i]));
        check_eq($sformatf("m%0d_rdata", i), bus.m_rdata, o_data[i]);
        if (o_wr[i] && !o_err[i]) shadow[widx(o_addr[i])] = o_wd[i];
      end
      outst[i] = 1'b0;
    end
    check_eq("gnt_onehot", 32'(g == 2'b11), 32'd0);
    if (g == 2'b00) check_eq("idle_mem_WE", 32'(mem_WE), 32'd0);
    for (int i = 0; i < 2; i++) begin
      if (g[i]) begin
        check_eq($sformatf("m%0d_gnt_req", i), 32'(pend[i]), 32'd1);
        check_eq($sformatf("m%0d_gnt_b2b", i), 32'(prev_g[i]), 32'd0);
        check_eq($sformatf("m%0d_gnt_wait", i), 32'(wait_cnt[i] <= 2), 32'd1);
        rej = exp_reject(i, wr[i], ad[i]);
        check_eq($sformatf("m%0d_mem_A", i), 32'(mem_A), ad[i]);
        check_eq($sformatf("m%0d_mem_WE", i), 32'(mem_WE), 32'(wr[i] && !rej));
        if (wr[i]) check_eq($sformatf("m%0d_mem_WD", i), mem_WD, wd[i]);
        outst[i]  = 1'b1;
        o_wr[i]   = wr[i];
        o_err[i]  = rej;
        o_addr[i] = ad[i];
        o_wd[i]   = wd[i];
        o_data[i] = (!wr[i] && !rej) ? shadow[widx(ad[i])] : 32'd0;
        pend[i]   = 1'b0;
      end else if (pend[i]) begin
        wait_cnt[i]++;
        if (wait_cnt[i] > 4) begin
          check_eq($sformatf("m%0d_gnt_timeout", i), 32'(wait_cnt[i]), 32'd4);
          pend[i] = 1'b0;
        end
      end
      prev_g[i] = g[i];
    end
  endtask

  task automatic tick();
    drive();
    rst_q = reset;
    @(negedge clk);
    cyc++;
    observe();
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((pend[0] || pend[1] || outst[0] || outst[1]) && n < max_cyc) begin
      tick();
      n++;
    end
    check_eq("drain", 32'(pend[0] || pend[1] || outst[0] || outst[1]), 32'd0);
  endtask

  function automatic int unsigned rand_addr();
    case ($urandom_range(0, 5))
      0:       return $urandom_range(0, 127) * 4;
      1, 2:    return 512 + $urandom_range(0, 63) * 4;
      3:       return 'h800 + $urandom_range(0, 511) * 4;
      4:       return 768 + $urandom_range(0, 319) * 4;
      default: return $urandom_range(0, 4095);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gnts;
    for (int i = 0; i < NWORDS; i++) shadow[i] = init_word(i);
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; wr[i] = 1'b0; ad[i] = 0; wd[i] = '0;
      outst[i] = 1'b0; prev_g[i] = 1'b0; wait_cnt[i] = 0;
    end

    // Reset state
    tick();
    mem_init = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Simultaneous requests straight after reset: m0 first, then m1
    issue(0, 1'b1, 'h204, 32'h11111111);
    issue(1, 1'b0, 'h000, 32'h0);
    tick();
    check_eq("t2_first_m0", 32'({bus.m1_gnt, bus.m0_gnt}), 32'd1);
    tick();
    check_eq("t2_then_m1", 32'({bus.m1_gnt, bus.m0_gnt}), 32'd2);
    check_eq("t2_rvalid0", 32'(bus.m0_rvalid), 32'd1);
    tick();
    check_eq("t2_rvalid1", 32'(bus.m1_rvalid), 32'd1);
    // rr is back at m0 after m1's grant
    issue(0, 1'b0, 'h204, 32'h0);
    issue(1, 1'b0, 'h204, 32'h0);
    tick();
    check_eq("t2_rr_m0", 32'({bus.m1_gnt, bus.m0_gnt}), 32'd1);
    drain(10);

    // Lone m0 read of data RAM
    issue(0, 1'b0, 'h200, 32'h0);
    tick();
    check_eq("t1_gnt_e1", 32'({bus.m1_gnt, bus.m0_gnt}), 32'd1);
    check_eq("t1_mem_A", 32'(mem_A), 32'h200);
    tick();
    check_eq("t1_rvalid_e2", 32'(bus.m0_rvalid), 32'd1);
    check_eq("t1_rdata", bus.m_rdata, 32'hDEADBEEF);
    drain(10);

    // Core write into instruction RAM is rejected; loader write is not
    issue(0, 1'b1, 'h010, 32'hCAFE0001);
    tick();
    tick();
    check_eq("t3_m0_err", 32'(bus.m0_err), 32'd1);
    check_eq("t3_iram_kept", mem_arr[4], init_word(4));
    issue(1, 1'b1, 'h010, 32'hCAFE0001);
    tick();
    tick();
    check_eq("t3_m1_err", 32'(bus.m1_err), 32'd0);
    issue(1, 1'b0, 'h010, 32'h0);
    tick();
    tick();
    check_eq("t3_readback", bus.m_rdata, 32'hCAFE0001);
    drain(10);

    // Misaligned and map-hole reads
    issue(1, 1'b0, 'h202, 32'h0);
    tick();
    tick();
    check_eq("t4_misalign_err", 32'(bus.m1_err), 32'd1);
    check_eq("t4_misalign_rdata", bus.m_rdata, 32'd0);
    issue(1, 1'b0, 'h400, 32'h0);
    tick();
    tick();
    check_eq("t4_hole_err", 32'(bus.m1_err), 32'd1);
    check_eq("t4_hole_rdata", bus.m_rdata, 32'd0);
    drain(10);

    // m0 holding req for peripheral reads: one grant every second cycle
    gnts = 0;
    issue(0, 1'b0, 'h800, 32'h0);
    for (int c = 0; c < 16; c++) begin
      tick();
      if (bus.m0_gnt) gnts++;
      if (!pend[0]) issue(0, 1'b0, 'h800, 32'h0);
    end
    check_eq("t5_grant_rate", 32'(gnts), 32'd8);
    pend[0] = 1'b0;
    drain(10);

    // Reset during an m1 write's access cycle cancels it
    issue(1, 1'b1, 'h208, 32'hBAD0BAD0);
    tick();
    check_eq("t6_gnt1", 32'(bus.m1_gnt), 32'd1);
    reset = 1'b1;
    pend[1] = 1'b0;
    tick();
    reset = 1'b0;
    check_eq("t6_no_write", mem_arr[130], init_word(130));
    issue(0, 1'b0, 'h204, 32'h0);
    issue(1, 1'b0, 'h208, 32'h0);
    tick();
    check_eq("t6_post_rst_m0", 32'({bus.m1_gnt, bus.m0_gnt}), 32'd1);
    drain(10);

    // Reset right after an m0 grant must also bring rr back to m0
    issue(0, 1'b0, 'h200, 32'h0);
    tick();
    reset = 1'b1;
    pend[0] = 1'b0;
    tick();
    reset = 1'b0;
    issue(0, 1'b0, 'h204, 32'h0);
    issue(1, 1'b0, 'h208, 32'h0);
    tick();
    check_eq("t6_rr_reset", 32'({bus.m1_gnt, bus.m0_gnt}), 32'd1);
    drain(10);

    // Random traffic from both requesters
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1)
          issue(i, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
      tick();
    end
    drain(20);

    // Final memory image against the shadow
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < NWORDS; i++) if (mem_arr[i] !== shadow[i]) bad++;
      check_eq("mem_image", 32'(bad), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the unified 12-bit byte-addressed memory (instruction RAM, data RAM, peripherals).
- Requester 0 is the multi-cycle core. Requester 1 is the program loader/debug port.
- Serialises accesses with round-robin priority, drives the single memory port from registers, and returns registered read data.
- Enforces alignment, map holes and instruction-region write protection.

Parameters:
- ADDR_W, 12, memory byte address width
- DATA_W, 32, data width
- INSTR_MEM_SIZE, 512, instruction region bytes [0, 512)
- DATA_MEM_SIZE, 256, data region bytes [512, 768)
- PERIPH_ADDR_START, 12'h800, peripheral region start (to 12'hFFF)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  access request; hold with fields stable until gnt seen
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  byte address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_gnt / m1_gnt  out  1  request accepted; high during the memory access cycle
- m0_rvalid / m1_rvalid  out  1  one-cycle response pulse, reads and writes
- m0_err / m1_err  out  1  qualifies rvalid: access rejected
- m_rdata  out  DATA_W  read data, shared by both requesters, valid with rvalid
- mem_A  out  ADDR_W  to memory address
- mem_WD  out  DATA_W  to memory write data
- mem_WE  out  1  to memory write enable
- mem_RD  in  DATA_W  from memory, combinational read

Behaviour:
- Reset values:
  - all outputs 0
  - FSM = IDLE
  - round-robin pointer rr = 0 (m0 favoured)
  - no access in flight
  - reset mid-access cancels it: no rvalid issued; a write suppressed by reset is not performed.
- FSM has two states, IDLE and ACCESS.
- Arbitration:
  - Evaluated each cycle over eligible requests.
  - A requester whose gnt is high this cycle is ineligible, which masks a req not yet dropped.
  - Both eligible: winner = rr; one eligible: that one.
- Acceptance:
  - At the edge the winner is chosen, latch addr/we/wdata/id into access registers.
  - Next cycle: state = ACCESS, gnt[id] = 1, memory driven from the registers.
  - rr <= ~id, so after a grant the other requester has priority.
- ACCESS cycle:
  - mem_A = latched addr; mem_WE = latched we AND NOT reject.
  - At the closing edge, m_rdata <= mem_RD for a valid read, else 0.
  - At that edge, rvalid[id] <= 1 and err[id] <= reject.
  - If another eligible request exists, go back-to-back to ACCESS with the new winner; else IDLE.
- Latency:
  - req sampled at edge E -> gnt during cycle E+1 -> rvalid/rdata during cycle E+2.
  - Peak throughput is one access per cycle when both requesters alternate.
  - A single requester gets one access per 2 cycles because of the gnt mask.
- Reject conditions: reject = any of the following.
  - Misalignment: addr[1:0] != 0.
  - Map hole: addr in [768, PERIPH_ADDR_START).
  - Write protection: requester 0 writes into the instruction region.
  - Requester 1 may write anywhere mapped.
  - A rejected access never asserts mem_WE; a rejected read returns m_rdata = 0.
- mem_WE is 0 in IDLE. mem_A/mem_WD hold their last value in IDLE; only mem_WE is qualifying.
- Simultaneous new requests at reset release: m0 wins.
- Address arithmetic is unsigned ADDR_W; region compares use parameters only.

Decomposition:
- Shared package/header holds the memory map constants (INSTR_MEM_SIZE, DATA_MEM_SIZE, PERIPH_ADDR_START) and FSM state encodings.
- Memory and arbiter both use these constants.
- One natural sub-module: mem_access_check, a combinational address/permission decoder that outputs reject and region.

Test Plan:
- m0 read at 0x200, data RAM word 0xDEADBEEF: m0_gnt at E+1 with mem_A=0x200 and mem_WE=0 -> m0_rvalid at E+2 with m_rdata=0xDEADBEEF, err=0.
- m0 and m1 both request at the same edge after reset (m0 write 0x204 <= 0x11111111, m1 read 0x000): m0 granted first, then m1 the next cycle -> rvalids on consecutive cycles, rr ends at 0.
- m0 write to 0x010 -> m0_err=1, mem_WE never 1, instruction RAM unchanged. The same write from m1 -> err=0 and a readback returns the data.
- Misaligned m1 read at 0x202 and hole read at 0x400 -> err=1, m_rdata=0, no mem_WE.
- m0 holds req continuously for reads at 0x800 (switch peripheral) -> a grant every 2nd cycle, never two gnts on consecutive cycles, and each rdata equals the sw value.
- reset asserted in the ACCESS cycle of an m1 write to 0x208 -> no rvalid, memory word unchanged, all outputs 0 the next cycle, and m0 wins the first post-reset conflict.
